// File: rtl/morse_pkg.sv
// Shared definitions for the Morse encoder slice.
// Holds the ASCII anchors, code-record widths, gap lengths in Morse units,
// the FSM state encoding and the packed code record that the ROM returns.
// Ports: none (package).
package morse_pkg;

  // ASCII anchors
  localparam logic [7:0] ASC_SPACE = 8'd32;
  localparam logic [7:0] ASC_0     = 8'd48;
  localparam logic [7:0] ASC_A     = 8'd65;
  localparam logic [7:0] ASC_LA    = 8'd97;

  // Code record widths
  localparam int LEN_W  = 3;
  localparam int ELEM_W = 5;

  // Element and gap lengths in Morse units
  localparam int DOT_U  = 1;
  localparam int DASH_U = 3;
  localparam int EGAP_U = 1;
  localparam int CGAP_U = 3;
  localparam int WGAP_U = 7;

  // Unit counter width; it must hold WGAP_U-1, the longest span
  localparam int UNIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_EGAP,
    S_CGAP,
    S_WGAP
  } state_t;

  // elems is left-aligned: bit ELEM_W-1 is the first element, 1 = dash.
  typedef struct packed {
    logic              valid;
    logic              is_space;
    logic [LEN_W-1:0]  len;
    logic [ELEM_W-1:0] elems;
  } code_t;

  function automatic code_t mk_code(input logic [LEN_W-1:0]  len,
                                    input logic [ELEM_W-1:0] elems);
    code_t c;
    c.valid    = 1'b1;
    c.is_space = 1'b0;
    c.len      = len;
    c.elems    = elems;
    return c;
  endfunction

endpackage

// File: rtl/morse_code_rom.sv
// Combinational ASCII -> Morse code lookup.
// Covers A-Z, 0-9 and space (ITU Morse, at most 5 elements).
// Optional feature: define MORSE_LOWERCASE_EN to map a-z onto the A-Z codes;
// without it, 97-122 are reported as unsupported (valid = 0).
// Ports:
//   char_in  in   8-bit ASCII code
//   code     out  {valid, is_space, len, elems}; elems left-aligned, 1 = dash
module morse_code_rom
  import morse_pkg::*;
(
  input  logic [7:0] char_in,
  output code_t      code
);

  logic [7:0] uc;

  always_comb begin
    // NOTE: every variable written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    uc = char_in;
`ifdef MORSE_LOWERCASE_EN
    if (char_in >= ASC_LA && char_in <= ASC_LA + 8'd25)
      uc = char_in - (ASC_LA - ASC_A);
`endif
  end

  always_comb begin
    code = '0;
    case (uc)
      ASC_SPACE: begin
        code.valid    = 1'b1;
        code.is_space = 1'b1;
      end
      "A": code = mk_code(3'd2, 5'b01000);
      "B": code = mk_code(3'd4, 5'b10000);
      "C": code = mk_code(3'd4, 5'b10100);
      "D": code = mk_code(3'd3, 5'b10000);
      "E": code = mk_code(3'd1, 5'b00000);
      "F": code = mk_code(3'd4, 5'b00100);
      "G": code = mk_code(3'd3, 5'b11000);
      "H": code = mk_code(3'd4, 5'b00000);
      "I": code = mk_code(3'd2, 5'b00000);
      "J": code = mk_code(3'd4, 5'b01110);
      "K": code = mk_code(3'd3, 5'b10100);
      "L": code = mk_code(3'd4, 5'b01000);
      "M": code = mk_code(3'd2, 5'b11000);
      "N": code = mk_code(3'd2, 5'b10000);
      "O": code = mk_code(3'd3, 5'b11100);
      "P": code = mk_code(3'd4, 5'b01100);
      "Q": code = mk_code(3'd4, 5'b11010);
      "R": code = mk_code(3'd3, 5'b01000);
      "S": code = mk_code(3'd3, 5'b00000);
      "T": code = mk_code(3'd1, 5'b10000);
      "U": code = mk_code(3'd3, 5'b00100);
      "V": code = mk_code(3'd4, 5'b00010);
      "W": code = mk_code(3'd3, 5'b01100);
      "X": code = mk_code(3'd4, 5'b10010);
      "Y": code = mk_code(3'd4, 5'b10110);
      "Z": code = mk_code(3'd4, 5'b11000);
      "0": code = mk_code(3'd5, 5'b11111);
      "1": code = mk_code(3'd5, 5'b01111);
      "2": code = mk_code(3'd5, 5'b00111);
      "3": code = mk_code(3'd5, 5'b00011);
      "4": code = mk_code(3'd5, 5'b00001);
      "5": code = mk_code(3'd5, 5'b00000);
      "6": code = mk_code(3'd5, 5'b10000);
      "7": code = mk_code(3'd5, 5'b11000);
      "8": code = mk_code(3'd5, 5'b11100);
      "9": code = mk_code(3'd5, 5'b11110);
      default: code = '0;
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// Serialises ASCII characters into an on/off Morse keying stream.
// One character per valid/ready handshake; marks are 1, all gaps are 0.
// Optional feature: MORSE_LOWERCASE_EN (handled in morse_code_rom) accepts
// a-z as A-Z; otherwise lowercase raises char_err.
// Parameters:
//   UNIT_CYCLES  clock cycles per Morse unit (>= 1)
//   CNT_W        cycle counter width, 2**CNT_W > UNIT_CYCLES
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   char_in     in   ASCII code, sampled only on transfer
//   char_valid  in   char_in valid this cycle
//   char_ready  out  encoder idle, can accept a character
//   signal_out  out  registered keying output, 1 = mark
//   busy        out  character or its trailing gap in progress
//   char_err    out  one-cycle pulse after an unsupported character
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       signal_out,
  output logic       busy,
  output logic       char_err
);

  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(UNIT_CYCLES - 1);

  state_t             state;
  logic [LEN_W-1:0]   len;      // elements still to send, including current
  logic [ELEM_W-1:0]  elems;    // current element at the MSB
  logic [CNT_W-1:0]   cyc_cnt;  // cycle within the current unit
  logic [UNIT_W-1:0]  unit_cnt; // unit within the current element or gap
  logic [UNIT_W-1:0]  unit_last;
  code_t              code;

  morse_code_rom u_rom (
    .char_in (char_in),
    .code    (code)
  );

  // Index of the final unit of whatever the FSM is currently emitting.
  always_comb begin
    unit_last = '0;
    case (state)
      S_MARK:  unit_last = elems[ELEM_W-1] ? UNIT_W'(DASH_U - 1) : UNIT_W'(DOT_U - 1);
      S_EGAP:  unit_last = UNIT_W'(EGAP_U - 1);
      S_CGAP:  unit_last = UNIT_W'(CGAP_U - 1);
      S_WGAP:  unit_last = UNIT_W'(WGAP_U - 1);
      default: unit_last = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      len        <= '0;
      elems      <= '0;
      cyc_cnt    <= '0;
      unit_cnt   <= '0;
      signal_out <= 1'b0;
      char_err   <= 1'b0;
    end else begin
      char_err <= 1'b0;
      if (state == S_IDLE) begin
        if (char_valid) begin
          cyc_cnt  <= '0;
          unit_cnt <= '0;
          if (code.valid && code.is_space) begin
            state <= S_WGAP;
          end else if (code.valid) begin
            len        <= code.len;
            elems      <= code.elems;
            signal_out <= 1'b1;
            state      <= S_MARK;
          end else begin
            char_err <= 1'b1;
          end
        end
      end else if (cyc_cnt != CYC_LAST) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end else begin
        cyc_cnt <= '0;
        if (unit_cnt != unit_last) begin
          unit_cnt <= unit_cnt + 1'b1;
        end else begin
          // Last cycle of the last unit: the only point where state changes.
          unit_cnt <= '0;
          case (state)
            S_MARK: begin
              signal_out <= 1'b0;
              len        <= len - 1'b1;
              elems      <= elems << 1;
              state      <= (len > LEN_W'(1)) ? S_EGAP : S_CGAP;
            end
            S_EGAP: begin
              signal_out <= 1'b1;
              state      <= S_MARK;
            end
            default: state <= S_IDLE; // end of CGAP or WGAP
          endcase
        end
      end
    end
  end

  assign char_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_morse_encoder.sv
// Self-checking bench for morse_encoder: two instances (1 and 4 cycles per
// unit) driven with directed and random characters, checked cycle by cycle
// against a dot/dash text model of ITU Morse.
module tb_morse_encoder;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] char0 = '0, char1 = '0;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic       ready0, ready1, sig0, sig1, busy0, busy1, err0, err1;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_q[$];

  string LETTERS [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                          "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                          "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                          "-.--", "--.."};
  string DIGITS [10] = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};

  always #5 clock = ~clock;

  morse_encoder #(.UNIT_CYCLES(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .char_in(char0), .char_valid(valid0),
    .char_ready(ready0), .signal_out(sig0), .busy(busy0), .char_err(err0));

  morse_encoder #(.UNIT_CYCLES(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .char_in(char1), .char_valid(valid1),
    .char_ready(ready1), .signal_out(sig1), .busy(busy1), .char_err(err1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int d);  return d == 0 ? ready0 : ready1; endfunction
  function automatic logic sig(input int d);  return d == 0 ? sig0   : sig1;   endfunction
  function automatic logic bsy(input int d);  return d == 0 ? busy0  : busy1;  endfunction
  function automatic logic err(input int d);  return d == 0 ? err0   : err1;   endfunction
  function automatic int   ucyc(input int d); return d == 0 ? 1 : 4;           endfunction

  task automatic drive(input int d, input logic [7:0] c, input logic v);
    if (d == 0) begin char0 = c; valid0 = v; end
    else        begin char1 = c; valid1 = v; end
  endtask

  // Dot/dash text for a character, empty when it has no Morse code.
  function automatic string pattern(input logic [7:0] c);
    logic [7:0] u = c;
`ifdef MORSE_LOWERCASE_EN
    if (c >= 8'd97 && c <= 8'd122) u = c - 8'd32;
`endif
    if (u >= 8'd65 && u <= 8'd90) return LETTERS[u - 8'd65];
    if (u >= 8'd48 && u <= 8'd57) return DIGITS[u - 8'd48];
    return "";
  endfunction

  task automatic push(input bit v, input int units, input int u);
    for (int i = 0; i < units * u; i++) exp_q.push_back(v);
  endtask

  // Expected per-cycle keying from transfer+1 until the encoder is idle again.
  task automatic build(input logic [7:0] c, input int u, output bit bad);
    string p;
    exp_q.delete();
    bad = 1'b0;
    if (c == 8'd32) begin
      push(1'b0, 7, u);
    end else begin
      p = pattern(c);
      if (p.len() == 0) bad = 1'b1;
      else begin
        for (int k = 0; k < p.len(); k++) begin
          if (k > 0) push(1'b0, 1, u);
          push(1'b1, (p[k] == "-") ? 3 : 1, u);
        end
        push(1'b0, 3, u);
      end
    end
  endtask

  task automatic send(input int d, input logic [7:0] c);
    bit bad;
    int tries = 0;
    build(c, ucyc(d), bad);
    while (rdy(d) !== 1'b1 && tries < 200) begin
      @(negedge clock);
      tries++;
    end
    check($sformatf("ready_before d%0d c%0d", d, c), rdy(d), 1);
    drive(d, c, 1'b1);
    @(negedge clock);
    drive(d, c, 1'b0);
    if (bad) begin
      check($sformatf("err_pulse d%0d c%0d", d, c), err(d), 1);
      check($sformatf("err_sig d%0d c%0d", d, c), sig(d), 0);
      check($sformatf("err_ready d%0d c%0d", d, c), rdy(d), 1);
      @(negedge clock);
      check($sformatf("err_clear d%0d c%0d", d, c), err(d), 0);
      check($sformatf("err_ready2 d%0d c%0d", d, c), rdy(d), 1);
    end else begin
      check($sformatf("no_err d%0d c%0d", d, c), err(d), 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clock);
        check($sformatf("sig d%0d c%0d [%0d]", d, c, i), sig(d), exp_q[i]);
        check($sformatf("busy d%0d c%0d [%0d]", d, c, i), bsy(d), 1);
      end
      @(negedge clock);
      check($sformatf("ready_after d%0d c%0d", d, c), rdy(d), 1);
      check($sformatf("idle_busy d%0d c%0d", d, c), bsy(d), 0);
      check($sformatf("idle_sig d%0d c%0d", d, c), sig(d), 0);
    end
  endtask

  initial begin
    bit bad;
    logic [7:0] c;
    int r;

    // Reset state
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_sig d%0d", d), sig(d), 0);
      check($sformatf("rst_busy d%0d", d), bsy(d), 0);
      check($sformatf("rst_ready d%0d", d), rdy(d), 1);
      check($sformatf("rst_err d%0d", d), err(d), 0);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed characters
    send(0, "E");
    send(0, "A");
    send(0, "0");   // back-to-back with 'A'
    send(1, "I");
    send(0, "T");
    send(0, " ");
    send(0, "#");
    send(0, "q");
    send(1, "q");
    send(1, " ");
    send(1, "5");

    // Reset during the second element of 'K'
    build("K", 1, bad);
    drive(0, "K", 1'b1);
    @(negedge clock);
    drive(0, "K", 1'b0);
    check("k_first", sig0, 1);
    repeat (4) @(negedge clock);
    check("k_second_elem", sig0, exp_q[4]);
    #1 reset_n = 1'b0;
    #1;
    check("k_abort_sig", sig0, 0);
    check("k_abort_ready", ready0, 1);
    check("k_abort_busy", busy0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send(0, "E");

    // Random characters across both instances
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 5);
      case (r)
        0, 5: c = 8'd65 + 8'($urandom_range(0, 25));
        1:    c = 8'd48 + 8'($urandom_range(0, 9));
        2:    c = 8'd32;
        3:    c = 8'd97 + 8'($urandom_range(0, 25));
        default: c = 8'($urandom_range(0, 255));
      endcase
      send(int'($urandom_range(0, 1)), c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
